i2s_rx_master: RTL and testbench

I2S master receiver for the board microphone. Generates the bit clock (`sck`) and word select (`ws`) from the 25 MHz system clock. Deserialises one selected channel of the MSB-first, one-bit-delayed I2S stream and truncates each sample to a narrow PCM word. The output is a one-cycle strobe, `sample_valid`, with a held `sample` bus that feeds the UART sender, the sample buffer and `dacpwm` downstream.

---
 rtl/i2s_rx_master_if.sv | 30 +++
 rtl/i2s_rx_master.sv | 137 +++++++++++++
 tb/tb_i2s_rx_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_master_if.sv
// i2s_rx_master_if: I2S pins (sck/ws/sd), channel select and PCM sample output
// of the I2S master receiver.
interface i2s_rx_master_if #(
  parameter int OUT_BITS = 8
);
  logic                sck;
  logic                ws;
  logic                sd;
  logic                sel_right;
  logic [OUT_BITS-1:0] sample;
  logic                sample_valid;

  modport master (
    output sck,
    output ws,
    output sample,
    output sample_valid,
    input  sd,
    input  sel_right
  );

  modport slave (
    input  sck,
    input  ws,
    input  sample,
    input  sample_valid,
    output sd,
    output sel_right
  );
endinterface

// File: rtl/i2s_rx_master.sv
// i2s_rx_master: I2S master receiver; generates sck/ws, captures one slot, strobes a truncated PCM word.
// Optional macro I2S_RX_DC_BLOCK_EN inserts a DC-removal stage (one extra clk of latency).
module i2s_rx_master #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_BITS   = 24,
  parameter int OUT_BITS      = 8,
  parameter int OFFSET_BINARY = 1,
  parameter int DC_SHIFT      = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  i2s_rx_master_if.master i2s_if
);
  localparam int              DW     = $clog2(CLK_DIV);
  localparam logic [DW-1:0]   DIV_TC = DW'(CLK_DIV - 1);
  localparam logic [4:0]      LAST_S = 5'(SAMPLE_BITS);

  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic                   sck_q, sck_d;
  logic                   ws_q, ws_d;
  logic [5:0]             bitcnt_q, bitcnt_d;
  logic                   sd_meta_q, sd_s_q;
  logic                   cap_sel_q, cap_sel_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d, word_x;
  logic [OUT_BITS-1:0]    sample_q, sample_d;
  logic                   valid_q, valid_d;

  logic                   tc;
  logic                   fall_evt;
  logic [4:0]             slot_idx;
  logic                   in_win;
  logic                   cap_last;

  function automatic logic [OUT_BITS-1:0] to_pcm(input logic [SAMPLE_BITS-1:0] w);
    logic [OUT_BITS-1:0] p;
    p             = w[SAMPLE_BITS-1 -: OUT_BITS];
    p[OUT_BITS-1] = p[OUT_BITS-1] ^ (OFFSET_BINARY != 0);
    return p;
  endfunction

  always_comb begin
    tc        = (div_cnt_q == DIV_TC);
    fall_evt  = tc && sck_q;
    div_cnt_d = tc ? '0 : div_cnt_q + DW'(1);
    sck_d     = tc ? ~sck_q : sck_q;
    bitcnt_d  = fall_evt ? bitcnt_q + 6'd1 : bitcnt_q;
    ws_d      = bitcnt_d[5];
    slot_idx  = bitcnt_q[4:0];

    // Channel choice is latched only when a new slot begins, so a mid-slot change never splits a sample.
    cap_sel_d = (fall_evt && (bitcnt_d[4:0] == 5'd0)) ? i2s_if.sel_right : cap_sel_q;

    in_win   = fall_evt && (bitcnt_q[5] == cap_sel_q) &&
               (slot_idx != 5'd0) && (slot_idx <= LAST_S);
    cap_last = in_win && (slot_idx == LAST_S);
    word_x   = (shift_q << 1) | SAMPLE_BITS'(sd_s_q);
    shift_d  = in_win ? word_x : shift_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      bitcnt_q  <= '0;
      sd_meta_q <= 1'b0;
      sd_s_q    <= 1'b0;
      cap_sel_q <= i2s_if.sel_right;
      shift_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      bitcnt_q  <= bitcnt_d;
      sd_meta_q <= i2s_if.sd;
      sd_s_q    <= sd_meta_q;
      cap_sel_q <= cap_sel_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
    end
  end

`ifdef I2S_RX_DC_BLOCK_EN
  localparam int                AW    = SAMPLE_BITS + DC_SHIFT;
  localparam logic signed [AW:0] Y_MAX = {{(AW-SAMPLE_BITS+2){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic signed [AW:0] Y_MIN = ~Y_MAX;

  logic signed [AW-1:0]   acc_q, acc_d, acc_fb;
  logic signed [AW:0]     x_ext, y_full;
  logic [SAMPLE_BITS-1:0] y_sat, y_q;
  logic                   y_vld_q;

  // y = x - acc/2^DC_SHIFT; the accumulator tracks the unsaturated y so the estimate never stalls.
  always_comb begin
    acc_fb = acc_q >>> DC_SHIFT;
    x_ext  = {{(AW+1-SAMPLE_BITS){word_x[SAMPLE_BITS-1]}}, word_x};
    y_full = x_ext - {acc_fb[AW-1], acc_fb};
    if (y_full > Y_MAX) begin
      y_sat = Y_MAX[SAMPLE_BITS-1:0];
    end else if (y_full < Y_MIN) begin
      y_sat = Y_MIN[SAMPLE_BITS-1:0];
    end else begin
      y_sat = y_full[SAMPLE_BITS-1:0];
    end
    acc_d    = cap_last ? acc_q + y_full[AW-1:0] : acc_q;
    sample_d = y_vld_q ? to_pcm(y_q) : sample_q;
    valid_d  = y_vld_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      y_vld_q <= cap_last;
      if (cap_last) begin
        y_q <= y_sat;
      end
    end
  end
`else
  always_comb begin
    sample_d = cap_last ? to_pcm(word_x) : sample_q;
    valid_d  = cap_last;
  end
`endif

  assign i2s_if.sck          = sck_q;
  assign i2s_if.ws           = ws_q;
  assign i2s_if.sample       = sample_q;
  assign i2s_if.sample_valid = valid_q;
endmodule

// File: tb/tb_i2s_rx_master.sv
`timescale 1ns/1ps
// tb_i2s_rx_master: default receiver plus a CLK_DIV=2, 8-bit corner receiver, each fed by a
// behavioural I2S microphone; strobe timing and values come from frame arithmetic.
module tb_i2s_rx_master;
  localparam int CDA = 4, SBA = 24, OBA = 8;
  localparam int CDB = 2, SBB = 8,  OBB = 8;
  localparam int DCS = 10;
`ifdef I2S_RX_DC_BLOCK_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int WIN = 1100;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  i2s_rx_master_if #(.OUT_BITS(OBA)) a_if ();
  i2s_rx_master_if #(.OUT_BITS(OBB)) b_if ();

  i2s_rx_master #(.CLK_DIV(CDA), .SAMPLE_BITS(SBA), .OUT_BITS(OBA), .OFFSET_BINARY(1), .DC_SHIFT(DCS))
    u_dut_a (.clk_i(clk), .rst_i(rst), .i2s_if(a_if.master));
  i2s_rx_master #(.CLK_DIV(CDB), .SAMPLE_BITS(SBB), .OUT_BITS(OBB), .OFFSET_BINARY(1), .DC_SHIFT(DCS))
    u_dut_b (.clk_i(clk), .rst_i(rst), .i2s_if(b_if.master));

  logic [31:0] a_left, a_right, b_left, b_right;
  int          a_pos, b_pos;
  int          n_chk, n_err;
  int          cyc;
  int          a_vc[$], b_vc[$], a_rise[$], b_rise[$];
  logic [7:0]  a_vs[$], b_vs[$];
  int          a_ws_bad, b_ws_bad, a_hold_bad, b_hold_bad;
  logic        a_psck, b_psck;
  logic [7:0]  a_psmp, b_psmp;
  longint      a_acc, b_acc;

  // Slot bit s (1..sb) carries word bit sb-s; index 0 and the tail are filler noise.
  function automatic logic mic_bit(input int pos, input logic [31:0] l, input logic [31:0] r, input int sb);
    logic [31:0] w;
    int          s;
    w = (pos >= 32) ? r : l;
    s = pos % 32;
    if (s >= 1 && s <= sb) return w[sb - s];
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge a_if.sck or posedge rst) begin
    if (rst) a_pos = 0;
    else     a_pos = (a_pos + 1) % 64;
    a_if.sd = mic_bit(a_pos, a_left, a_right, SBA);
  end

  always @(negedge b_if.sck or posedge rst) begin
    if (rst) b_pos = 0;
    else     b_pos = (b_pos + 1) % 64;
    b_if.sd = mic_bit(b_pos, b_left, b_right, SBB);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int first_strobe(input int cd, input int sb, input logic sel);
    return 2 * cd * (32 * int'(sel) + sb + 1) + LAT;
  endfunction

  task automatic model_out(input logic [31:0] w, input int sb, input int ob,
                           inout longint acc, output logic [7:0] e);
    longint x, lim;
    x   = longint'(w) & ((longint'(1) << sb) - 1);
    lim = longint'(1) << (sb - 1);
    if (x >= lim) x = x - (lim << 1);
`ifdef I2S_RX_DC_BLOCK_EN
    x   = x - (acc >>> DCS);
    acc = acc + x;
    if (x > lim - 1) x = lim - 1;
    if (x < -lim)    x = -lim;
`endif
    e        = 8'((x >> (sb - ob)) & ((longint'(1) << ob) - 1));
    e[ob-1]  = ~e[ob-1];
  endtask

  task automatic watch(input int ncyc, input int stop_pos, output bit hit);
    hit = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (a_if.sample_valid === 1'b1) begin
        a_vc.push_back(cyc);
        a_vs.push_back(a_if.sample);
      end else if (a_if.sample !== a_psmp) a_hold_bad++;
      if (b_if.sample_valid === 1'b1) begin
        b_vc.push_back(cyc);
        b_vs.push_back(b_if.sample);
      end else if (b_if.sample !== b_psmp) b_hold_bad++;
      if (a_if.sck === 1'b1 && a_psck === 1'b0) a_rise.push_back(cyc);
      if (b_if.sck === 1'b1 && b_psck === 1'b0) b_rise.push_back(cyc);
      if (a_if.ws !== (a_pos >= 32)) a_ws_bad++;
      if (b_if.ws !== (b_pos >= 32)) b_ws_bad++;
      a_psck = a_if.sck;
      b_psck = b_if.sck;
      a_psmp = a_if.sample;
      b_psmp = b_if.sample;
      if (stop_pos >= 0 && a_pos == stop_pos) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic rst_assert();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_release();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    a_vc.delete(); a_vs.delete(); a_rise.delete();
    b_vc.delete(); b_vs.delete(); b_rise.delete();
    a_ws_bad = 0; b_ws_bad = 0; a_hold_bad = 0; b_hold_bad = 0;
    a_psck = 1'b0; b_psck = 1'b0; a_psmp = '0; b_psmp = '0;
    a_acc = 0; b_acc = 0;
  endtask

  // Strobes expected at first, first+period, ... up to the end of the watch window.
  task automatic check_run(input string tag, input bit is_b, input int first, input int period,
                           input logic [31:0] w);
    int         sz, n, c;
    logic [7:0] v, e;
    n  = (WIN - first) / period + 1;
    sz = is_b ? b_vc.size() : a_vc.size();
    check({tag, " strobe count"}, sz, n);
    for (int i = 0; i < n; i++) begin
      c = is_b ? qat(b_vc, i) : qat(a_vc, i);
      if (i < sz) v = is_b ? b_vs[i] : a_vs[i];
      else        v = 'x;
      check({tag, " strobe cycle"}, c, first + i * period);
      if (is_b) model_out(w, SBB, OBB, b_acc, e);
      else      model_out(w, SBA, OBA, a_acc, e);
      check({tag, " sample"}, v, e);
    end
  endtask

  task automatic check_side(input string tag);
    check({tag, " A ws pattern"}, a_ws_bad, 0);
    check({tag, " B ws pattern"}, b_ws_bad, 0);
    check({tag, " A sample hold"}, a_hold_bad, 0);
    check({tag, " B sample hold"}, b_hold_bad, 0);
  endtask

  initial begin
    bit         hit;
    logic [7:0] e;
    logic       sa, sb;
    rst = 1'b0;
    n_chk = 0;
    n_err = 0;
    a_if.sel_right = 1'b0;
    b_if.sel_right = 1'b0;
    a_left  = 32'h7A5C31;
    a_right = 32'h123456;
    b_left  = 32'h80;
    b_right = 32'h80;

    // Reset values
    rst_assert();
    check("rst A sck", a_if.sck, 1'b0);
    check("rst A ws", a_if.ws, 1'b0);
    check("rst A sample", a_if.sample, 8'h00);
    check("rst A valid", a_if.sample_valid, 1'b0);
    check("rst B sample", b_if.sample, 8'h00);
    check("rst B valid", b_if.sample_valid, 1'b0);
    rst_release();

    // Left slot, default parameters; B corner: CLK_DIV=2, 8-bit, constant 0x80
    watch(WIN, -1, hit);
    check("left A first sample", (a_vs.size() > 0) ? a_vs[0] : 8'hxx, 8'hFA);
    check("corner B first sample", (b_vs.size() > 0) ? b_vs[0] : 8'hxx, 8'h00);
    check("A first sck rise", qat(a_rise, 0), CDA);
    check("A sck period", qat(a_rise, 1) - qat(a_rise, 0), 2 * CDA);
    check("B first sck rise", qat(b_rise, 0), CDB);
    check("B sck period", qat(b_rise, 1) - qat(b_rise, 0), 2 * CDB);
    check_run("left A", 1'b0, first_strobe(CDA, SBA, 1'b0), 128 * CDA, a_left);
    check_run("corner B", 1'b1, first_strobe(CDB, SBB, 1'b0), 128 * CDB, b_left);
    check_side("left");

    // Right slot
    a_if.sel_right = 1'b1;
    rst_assert();
    rst_release();
    watch(WIN, -1, hit);
    check("right A first sample", (a_vs.size() > 0) ? a_vs[0] : 8'hxx, 8'h92);
    check_run("right A", 1'b0, first_strobe(CDA, SBA, 1'b1), 128 * CDA, a_right);

    // Reset at bitcnt=40 (inside the selected right slot)
    watch(1000, 40, hit);
    check("reach bitcnt 40", hit, 1'b1);
    rst_assert();
    check("midrst A valid", a_if.sample_valid, 1'b0);
    check("midrst A sample", a_if.sample, 8'h00);
    check("midrst A sck", a_if.sck, 1'b0);
    check("midrst A ws", a_if.ws, 1'b0);
    rst_release();
    watch(WIN, -1, hit);
    check_run("after midrst A", 1'b0, first_strobe(CDA, SBA, 1'b1), 128 * CDA, a_right);
    check_side("midrst");

    // Channel switch at s=10 of the left slot
    a_left  = $urandom & 32'hFF_FFFF;
    a_right = $urandom & 32'hFF_FFFF;
    a_if.sel_right = 1'b0;
    rst_assert();
    rst_release();
    watch(600, 10, hit);
    check("reach s=10", hit, 1'b1);
    a_if.sel_right = 1'b1;
    watch(WIN - cyc, -1, hit);
    check("switch strobe count", a_vc.size(), 3);
    check("switch strobe0 cycle", qat(a_vc, 0), first_strobe(CDA, SBA, 1'b0));
    model_out(a_left, SBA, OBA, a_acc, e);
    check("switch strobe0 old channel", (a_vs.size() > 0) ? a_vs[0] : 8'hxx, e);
    check("switch strobe1 cycle", qat(a_vc, 1), first_strobe(CDA, SBA, 1'b1));
    model_out(a_right, SBA, OBA, a_acc, e);
    check("switch strobe1 new channel", (a_vs.size() > 1) ? a_vs[1] : 8'hxx, e);
    check("switch strobe2 cycle", qat(a_vc, 2), first_strobe(CDA, SBA, 1'b1) + 128 * CDA);

    // Random words, channels and reset points
    for (int t = 0; t < 5; t++) begin
      a_left  = $urandom & 32'hFF_FFFF;
      a_right = $urandom & 32'hFF_FFFF;
      b_left  = $urandom & 32'hFF;
      b_right = $urandom & 32'hFF;
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      a_if.sel_right = sa;
      b_if.sel_right = sb;
      watch($urandom_range(30, 1500), -1, hit);
      rst_assert();
      check("rand rst A valid", a_if.sample_valid, 1'b0);
      check("rand rst B valid", b_if.sample_valid, 1'b0);
      rst_release();
      watch(WIN, -1, hit);
      check_run("rand A", 1'b0, first_strobe(CDA, SBA, sa), 128 * CDA, sa ? a_right : a_left);
      check_run("rand B", 1'b1, first_strobe(CDB, SBB, sb), 128 * CDB, sb ? b_right : b_left);
      check_side("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
